// File: rtl/ysyx_22050710_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between the IFU and the LSU.
// One transaction is in flight at a time: IDLE -> REQ -> RESP -> DONE -> IDLE.
module ysyx_22050710_mem_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,

  input  logic                    i_if_req_valid,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  output logic                    o_if_req_ready,
  output logic                    o_if_resp_valid,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,

  input  logic                    i_ls_req_valid,
  input  logic                    i_ls_wen,
  input  logic [ADDR_WIDTH-1:0]   i_ls_addr,
  input  logic [DATA_WIDTH-1:0]   i_ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_ls_wmask,
  output logic                    o_ls_req_ready,
  output logic                    o_ls_resp_valid,
  output logic [DATA_WIDTH-1:0]   o_ls_rdata,

  output logic                    o_mem_req_valid,
  output logic                    o_mem_wen,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wmask,
  input  logic                    i_mem_req_ready,
  input  logic                    i_mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    ownerLs_q, ownerLs_d;
  logic                    lastLs_q, lastLs_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0]   wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0]   ifRdata_q, ifRdata_d;
  logic [DATA_WIDTH-1:0]   lsRdata_q, lsRdata_d;

  logic ifWin;
  logic lsWin;
  logic inReq;

  // On a tie the unit that was not granted last wins; lastLs_q=1 means IFU is next.
  assign ifWin = i_if_req_valid && (!i_ls_req_valid || lastLs_q);
  assign lsWin = i_ls_req_valid && (!i_if_req_valid || !lastLs_q);
  assign inReq = (state_q == REQ);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      ownerLs_q <= 1'b0;
      lastLs_q  <= 1'b1;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      ifRdata_q <= '0;
      lsRdata_q <= '0;
    end else begin
      state_q   <= state_d;
      ownerLs_q <= ownerLs_d;
      lastLs_q  <= lastLs_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      ifRdata_q <= ifRdata_d;
      lsRdata_q <= lsRdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ownerLs_d      = ownerLs_q;
    lastLs_d       = lastLs_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    ifRdata_d      = ifRdata_q;
    lsRdata_d      = lsRdata_q;
    o_if_req_ready = 1'b0;
    o_ls_req_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_rst && ifWin) begin
          o_if_req_ready = 1'b1;
          addr_d         = i_if_addr;
          wen_d          = 1'b0;
          wdata_d        = '0;
          wmask_d        = '0;
          ownerLs_d      = 1'b0;
          lastLs_d       = 1'b0;
          state_d        = REQ;
        end else if (i_rst && lsWin) begin
          o_ls_req_ready = 1'b1;
          addr_d         = i_ls_addr;
          wen_d          = i_ls_wen;
          wdata_d        = i_ls_wdata;
          wmask_d        = i_ls_wmask;
          ownerLs_d      = 1'b1;
          lastLs_d       = 1'b1;
          state_d        = REQ;
        end
      end
      REQ: begin
        if (i_mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // Store responses carry no data back to the LSU.
        if (i_mem_resp_valid) begin
          if (ownerLs_q) begin
            lsRdata_d = wen_q ? '0 : i_mem_rdata;
          end else begin
            ifRdata_d = i_mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_mem_req_valid = inReq;
  assign o_mem_wen       = inReq ? wen_q : 1'b0;
  assign o_mem_addr      = inReq ? addr_q : '0;
  assign o_mem_wdata     = inReq ? wdata_q : '0;
  assign o_mem_wmask     = inReq ? wmask_q : '0;

  assign o_if_resp_valid = (state_q == DONE) && !ownerLs_q;
  assign o_ls_resp_valid = (state_q == DONE) && ownerLs_q;
  assign o_if_rdata      = ifRdata_q;
  assign o_ls_rdata      = lsRdata_q;

endmodule

// File: tb/tb_ysyx_22050710_mem_arbiter.sv
// Directed and randomized bench for ysyx_22050710_mem_arbiter with a
// transaction-level model of grant order and returned data.
module tb_ysyx_22050710_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req_valid;
  logic [63:0] i_if_addr;
  logic        o_if_req_ready;
  logic        o_if_resp_valid;
  logic [63:0] o_if_rdata;
  logic        i_ls_req_valid;
  logic        i_ls_wen;
  logic [63:0] i_ls_addr;
  logic [63:0] i_ls_wdata;
  logic [7:0]  i_ls_wmask;
  logic        o_ls_req_ready;
  logic        o_ls_resp_valid;
  logic [63:0] o_ls_rdata;
  logic        o_mem_req_valid;
  logic        o_mem_wen;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_req_ready;
  logic        i_mem_resp_valid;
  logic [63:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;

  // Model state: who was granted last, and the data each unit last saw.
  bit          lastLs;
  logic [63:0] ifData;
  logic [63:0] lsData;

  ysyx_22050710_mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_if_req_valid   (i_if_req_valid),
    .i_if_addr        (i_if_addr),
    .o_if_req_ready   (o_if_req_ready),
    .o_if_resp_valid  (o_if_resp_valid),
    .o_if_rdata       (o_if_rdata),
    .i_ls_req_valid   (i_ls_req_valid),
    .i_ls_wen         (i_ls_wen),
    .i_ls_addr        (i_ls_addr),
    .i_ls_wdata       (i_ls_wdata),
    .i_ls_wmask       (i_ls_wmask),
    .o_ls_req_ready   (o_ls_req_ready),
    .o_ls_resp_valid  (o_ls_resp_valid),
    .o_ls_rdata       (o_ls_rdata),
    .o_mem_req_valid  (o_mem_req_valid),
    .o_mem_wen        (o_mem_wen),
    .o_mem_addr       (o_mem_addr),
    .o_mem_wdata      (o_mem_wdata),
    .o_mem_wmask      (o_mem_wmask),
    .i_mem_req_ready  (i_mem_req_ready),
    .i_mem_resp_valid (i_mem_resp_valid),
    .i_mem_rdata      (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic applyReset();
    @(negedge i_clk);
    i_rst            = 1'b0;
    i_if_req_valid   = 1'b0;
    i_ls_req_valid   = 1'b0;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    @(negedge i_clk);
    #1;
    lastLs = 1'b1;
    ifData = '0;
    lsData = '0;
    checkOutput("rst_if_ready", o_if_req_ready, 0);
    checkOutput("rst_ls_ready", o_ls_req_ready, 0);
    checkOutput("rst_mem_valid", o_mem_req_valid, 0);
    checkOutput("rst_if_resp", o_if_resp_valid, 0);
    checkOutput("rst_ls_resp", o_ls_resp_valid, 0);
    checkOutput("rst_if_rdata", o_if_rdata, 0);
    checkOutput("rst_ls_rdata", o_ls_rdata, 0);
    i_rst = 1'b1;
  endtask

  // One complete transaction starting in IDLE; requesters stay asserted until DONE.
  task automatic applyStimulus(input bit ifv, input bit lsv, input bit lsWen,
                               input logic [63:0] ifAddr, input logic [63:0] lsAddr,
                               input logic [63:0] lsWdata, input logic [7:0] lsWmask,
                               input int readyDelay, input int respDelay,
                               input logic [63:0] memData);
    bit          winLs;
    logic [63:0] expAddr;
    logic [63:0] expWdata;
    logic [7:0]  expMask;
    bit          expWen;
    winLs    = lsv && (!ifv || !lastLs);
    expAddr  = winLs ? lsAddr : ifAddr;
    expWen   = winLs && lsWen;
    expWdata = winLs ? lsWdata : 64'd0;
    expMask  = winLs ? lsWmask : 8'd0;

    @(negedge i_clk);
    i_if_req_valid   = ifv;
    i_if_addr        = ifAddr;
    i_ls_req_valid   = lsv;
    i_ls_wen         = lsWen;
    i_ls_addr        = lsAddr;
    i_ls_wdata       = lsWdata;
    i_ls_wmask       = lsWmask;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    #1;
    checkOutput("idle_if_ready", o_if_req_ready, !winLs);
    checkOutput("idle_ls_ready", o_ls_req_ready, winLs);
    checkOutput("idle_mem_valid", o_mem_req_valid, 0);
    lastLs = winLs;

    for (int i = 0; i <= readyDelay; i++) begin
      @(negedge i_clk);
      i_mem_req_ready  = (i == readyDelay);
      i_mem_resp_valid = (i < readyDelay) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_mem_rdata      = rand64();
      #1;
      checkOutput("req_mem_valid", o_mem_req_valid, 1);
      checkOutput("req_mem_addr", o_mem_addr, expAddr);
      checkOutput("req_mem_wen", o_mem_wen, expWen);
      checkOutput("req_mem_wdata", o_mem_wdata, expWdata);
      checkOutput("req_mem_wmask", o_mem_wmask, expMask);
      checkOutput("req_readys", {o_if_req_ready, o_ls_req_ready}, 0);
      checkOutput("req_resps", {o_if_resp_valid, o_ls_resp_valid}, 0);
    end

    for (int i = 0; i <= respDelay; i++) begin
      @(negedge i_clk);
      i_mem_req_ready  = 1'b0;
      i_mem_resp_valid = (i == respDelay);
      i_mem_rdata      = (i == respDelay) ? memData : rand64();
      #1;
      checkOutput("resp_mem_valid", o_mem_req_valid, 0);
      checkOutput("resp_readys", {o_if_req_ready, o_ls_req_ready}, 0);
      checkOutput("resp_resps", {o_if_resp_valid, o_ls_resp_valid}, 0);
    end

    @(negedge i_clk);
    i_mem_resp_valid = 1'b0;
    i_mem_rdata      = rand64();
    #1;
    if (winLs) lsData = expWen ? 64'd0 : memData;
    else       ifData = memData;
    checkOutput("done_if_resp", o_if_resp_valid, !winLs);
    checkOutput("done_ls_resp", o_ls_resp_valid, winLs);
    checkOutput("done_if_rdata", o_if_rdata, ifData);
    checkOutput("done_ls_rdata", o_ls_rdata, lsData);
    checkOutput("done_readys", {o_if_req_ready, o_ls_req_ready}, 0);
    checkOutput("done_mem_valid", o_mem_req_valid, 0);
  endtask

  initial begin
    i_rst = 1'b0;
    i_if_addr = '0; i_ls_wen = 1'b0; i_ls_addr = '0; i_ls_wdata = '0; i_ls_wmask = '0;
    i_mem_rdata = '0;
    applyReset();

    // Zero-wait IFU fetch: ready at cycle 0, mem valid at 1, response at 3.
    applyStimulus(1, 0, 0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 0, 0, 64'h0000_0013_0000_0297);

    // LSU store: data returned to the LSU must read as zero.
    applyStimulus(0, 1, 1, 64'h0, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 0, 0, rand64());

    // Continuous contention: grants alternate starting with the IFU.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 0, rand64(), rand64(), rand64(), 8'($urandom), 0, 0, rand64());
    end

    // Memory holds off acceptance for five cycles.
    applyStimulus(0, 1, 0, 64'h0, 64'h8000_2000, 64'h0, 8'h00, 5, 2, rand64());

    // Stray memory response while idle is ignored.
    @(negedge i_clk);
    i_if_req_valid   = 1'b0;
    i_ls_req_valid   = 1'b0;
    i_mem_resp_valid = 1'b1;
    i_mem_rdata      = rand64();
    #1;
    checkOutput("idle_stray_resps", {o_if_resp_valid, o_ls_resp_valid}, 0);
    @(negedge i_clk);
    i_mem_resp_valid = 1'b0;
    #1;
    checkOutput("idle_stray_after", {o_if_resp_valid, o_ls_resp_valid}, 0);
    checkOutput("idle_stray_rdata", o_if_rdata, ifData);
    applyStimulus(1, 0, 0, 64'h8000_0008, 64'h0, 64'h0, 8'h00, 1, 1, rand64());

    // Reset during RESP drops the transaction; a late response is ignored.
    @(negedge i_clk);
    i_if_req_valid = 1'b1;
    i_if_addr      = 64'h8000_0010;
    #1;
    checkOutput("rr_if_ready", o_if_req_ready, 1);
    @(negedge i_clk);
    i_if_req_valid  = 1'b0;
    i_mem_req_ready = 1'b1;
    @(negedge i_clk);
    i_mem_req_ready = 1'b0;
    #1;
    checkOutput("rr_in_resp", o_mem_req_valid, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst            = 1'b1;
    i_mem_resp_valid = 1'b1;
    i_mem_rdata      = rand64();
    lastLs = 1'b1;
    ifData = '0;
    lsData = '0;
    #1;
    checkOutput("rr_outputs", {o_if_req_ready, o_ls_req_ready, o_if_resp_valid, o_ls_resp_valid,
                               o_mem_req_valid, o_mem_wen}, 0);
    checkOutput("rr_mem_addr", o_mem_addr, 0);
    checkOutput("rr_if_rdata", o_if_rdata, 0);
    checkOutput("rr_ls_rdata", o_ls_rdata, 0);
    @(negedge i_clk);
    i_mem_resp_valid = 1'b0;
    #1;
    checkOutput("rr_late_resp", {o_if_resp_valid, o_ls_resp_valid, o_mem_req_valid}, 0);
    applyStimulus(1, 0, 0, 64'h8000_0018, 64'h0, 64'h0, 8'h00, 0, 0, rand64());
    applyReset();
    applyStimulus(1, 1, 1, 64'h8000_0020, 64'h8000_3000, rand64(), 8'hFF, 0, 0, rand64());

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      bit ifv;
      bit lsv;
      ifv = 1'($urandom_range(0, 1));
      lsv = ifv ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(ifv, lsv, 1'($urandom_range(0, 1)), {rand64()} & ~64'h7, rand64(),
                    rand64(), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), rand64());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_mem_arbiter.md
Name: ysyx_22050710_mem_arbiter

Overview:
- Shares the single physical memory port between the IFU (instruction fetch, read-only) and the LSU (data load/store).
- Accepts one request at a time using round-robin arbitration when both units request in the same cycle.
- Sequences the downstream memory handshake and routes the response back to the unit that made the request.
- Sits between IFU/LSU and the pmem bridge; only one transaction is outstanding at any time.

Parameters:
- ADDR_WIDTH, 64, address width on all ports.
- DATA_WIDTH, 64, data width on all ports. Byte mask width is DATA_WIDTH/8.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous, active-low reset
- i_if_req_valid  input  1  IFU read request
- i_if_addr  input  ADDR_WIDTH  IFU fetch address (8-byte aligned word)
- o_if_req_ready  output  1  IFU request accepted this cycle
- o_if_resp_valid  output  1  one-cycle pulse; o_if_rdata valid
- o_if_rdata  output  DATA_WIDTH  fetched doubleword
- i_ls_req_valid  input  1  LSU request
- i_ls_wen  input  1  1 = store, 0 = load
- i_ls_addr  input  ADDR_WIDTH  LSU address
- i_ls_wdata  input  DATA_WIDTH  store data
- i_ls_wmask  input  DATA_WIDTH/8  store byte enables
- o_ls_req_ready  output  1  LSU request accepted this cycle
- o_ls_resp_valid  output  1  one-cycle pulse; load data valid or store done
- o_ls_rdata  output  DATA_WIDTH  load data (0 for stores)
- o_mem_req_valid  output  1  memory request
- o_mem_wen  output  1  memory write
- o_mem_addr  output  ADDR_WIDTH  memory address
- o_mem_wdata  output  DATA_WIDTH  memory write data
- o_mem_wmask  output  DATA_WIDTH/8  memory byte mask
- i_mem_req_ready  input  1  memory accepts request
- i_mem_resp_valid  input  1  memory response
- i_mem_rdata  input  DATA_WIDTH  memory read data

Behaviour:
- Reset (i_rst == 0 at a posedge):
  - State goes to IDLE and the priority pointer is set so the IFU wins the first tie.
  - All outputs go to 0.
  - Any in-flight transaction is dropped with no response.
  - A late i_mem_resp_valid after reset is ignored.
- State machine:
  - IDLE → REQ: a request is accepted.
  - REQ → RESP: i_mem_req_ready == 1 while o_mem_req_valid == 1.
  - RESP → DONE: i_mem_resp_valid == 1.
  - DONE → IDLE: always, after one cycle.
- IDLE:
  - o_*_req_ready is combinational and asserted only for the winner.
  - Winner rule: a single requester wins. If both request, the unit not granted last wins.
  - On acceptance: addr, wen, wdata and wmask are registered, the owner and the priority pointer are updated, and the state moves to REQ. IFU requests are registered with wen = 0 and wmask = 0.
  - No req_ready is asserted in REQ, RESP or DONE.
- REQ:
  - o_mem_req_valid = 1 and the o_mem_* signals are driven from the registered request.
  - These signals are held stable until i_mem_req_ready.
- RESP:
  - o_mem_req_valid = 0; the block waits for i_mem_resp_valid with no timeout.
  - i_mem_rdata is captured on the cycle i_mem_resp_valid is seen.
- DONE:
  - The owner's resp_valid is 1 for exactly one cycle with the registered rdata.
  - The other unit's resp_valid stays 0.
  - o_ls_rdata is forced to 0 for a store.
  - Requesters must accept the response in that cycle (no resp_ready).
- Latency: request accepted at cycle N → o_mem_req_valid at N+1. With zero-wait memory (ready at N+1, resp at N+2), resp_valid is asserted at N+3. Back-to-back: the next accept happens at the earliest in DONE+1.
- i_mem_resp_valid seen in IDLE or REQ is ignored (protocol violation, no state change).
- rdata registers hold their value between responses. Only the resp_valid pulse qualifies them.
- Starvation bound: with both units requesting continuously, grants strictly alternate.

Test Plan:
- Reset, then IFU only: i_if_addr = 0x80000000. Memory ready at once, resp one cycle later with rdata = 0x0000001300000297.
  - Expect o_if_req_ready at cycle 0, o_mem_req_valid at cycle 1 with o_mem_addr = 0x80000000 and wen = 0.
  - Expect o_if_resp_valid pulse at cycle 3 with that data, and o_ls_resp_valid = 0 throughout.
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F.
  - Expect o_mem_wen = 1 with matching wdata and wmask.
  - Expect o_ls_resp_valid pulse with o_ls_rdata = 0.
- Both units request continuously for 4 transactions: grant order is IFU, LSU, IFU, LSU.
- Memory stalls i_mem_req_ready low for 5 cycles:
  - o_mem_req_valid and the o_mem_* signals stay constant for those 5 cycles.
  - No req_ready is asserted to either unit until the transaction completes.
- Reset asserted in RESP, and memory then pulses i_mem_resp_valid:
  - No resp_valid to either unit and all outputs are 0.
  - The next IFU request completes normally.
- i_mem_resp_valid pulsed while in IDLE: no resp_valid output and the state is unchanged.
